// File: rtl/dmem_store_queue_responder_if.sv
// Request/response bundle between the load/store unit and the store-queue responder.
// The LSU owns the request fields; the responder owns ready, the load response and queue status.
interface dmem_store_queue_responder_if #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 5,
  parameter int SQ_DEPTH = 4
);
  localparam int CW = $clog2(SQ_DEPTH) + 1;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_store_i;
  logic [15:0]       req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic              rsp_valid_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [CW-1:0]     sq_count_o;
  logic              sq_empty_o;

  modport master (
    output req_valid_i, req_store_i, req_addr_i, req_data_i, req_tag_i,
    input  req_ready_o, rsp_valid_o, rsp_tag_o, rsp_data_o, sq_count_o, sq_empty_o
  );

  modport slave (
    input  req_valid_i, req_store_i, req_addr_i, req_data_i, req_tag_i,
    output req_ready_o, rsp_valid_o, rsp_tag_o, rsp_data_o, sq_count_o, sq_empty_o
  );
endinterface

// File: rtl/dmem_store_queue_responder.sv
// Store-queue responder: in-order store buffer draining one entry per cycle into a word array,
// loads forwarded from the youngest matching queued store and answered after two edges.
module dmem_store_queue_responder #(
  parameter int DEPTH    = 8,
  parameter int SQ_DEPTH = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 5
) (
  input logic                        clock_i,
  input logic                        reset_n_i,
  dmem_store_queue_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [AW-1:0]     sq_idx [SQ_DEPTH];
  logic [DATA_W-1:0] sq_dat [SQ_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     sq_count;

  logic              ready;
  logic              acc_p0;
  logic              st_p0;
  logic              vld_p0;
  logic              drain;
  logic [AW-1:0]     idx_p0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p2;
  logic [TAG_W-1:0]  tag_p2;
  logic [DATA_W-1:0] data_p2;
  logic              addr_unused;

  assign ready       = (sq_count < CW'(SQ_DEPTH));
  assign acc_p0      = bus.req_valid_i & ready;
  assign st_p0       = acc_p0 & bus.req_store_i;
  assign vld_p0      = acc_p0 & ~bus.req_store_i;
  assign drain       = (sq_count != '0);
  assign idx_p0      = bus.req_addr_i[AW-1:0];
  assign addr_unused = ^bus.req_addr_i[15:AW];

  // Stage p0: search every live entry, oldest to youngest, so the youngest match wins.
  // The entry draining this edge is still live here, so the array read never misses it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      if ((CW'(k) < sq_count) && (sq_idx[head + PW'(k)] == idx_p0)) begin
        fwd_hit  = 1'b1;
        fwd_data = sq_dat[head + PW'(k)];
      end
    end
  end

  assign data_p0 = fwd_hit ? fwd_data : mem[idx_p0];

  // Queue payload and array contents carry no reset; pointers and count make them live.
  always_ff @(posedge clock_i) begin
    if (st_p0) begin
      sq_idx[tail] <= idx_p0;
      sq_dat[tail] <= bus.req_data_i;
    end
    if (drain) begin
      mem[sq_idx[head]] <= sq_dat[head];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head     <= '0;
      tail     <= '0;
      sq_count <= '0;
    end else begin
      if (st_p0) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({st_p0, drain})
        2'b10:   sq_count <= sq_count + CW'(1);
        2'b01:   sq_count <= sq_count - CW'(1);
        default: sq_count <= sq_count;
      endcase
    end
  end

  // Stage p1: load data and tag captured at the accept edge.
  always_ff @(posedge clock_i) begin
    if (vld_p0) begin
      tag_p1  <= bus.req_tag_i;
      data_p1 <= data_p0;
    end
  end

  // Stage p2: response registers hold their last value between completions.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      tag_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        tag_p2  <= tag_p1;
        data_p2 <= data_p1;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = vld_p2;
  assign bus.rsp_tag_o   = tag_p2;
  assign bus.rsp_data_o  = data_p2;
  assign bus.sq_count_o  = sq_count;
  assign bus.sq_empty_o  = (sq_count == '0);
endmodule
